// File: rtl/elevator_dest_sched_if.sv
// Request/destination bundle for the elevator destination scheduler.
// Optional cancel signals exist only when ELEVATOR_DEST_CANCEL_EN is defined.
interface elevator_dest_sched_if #(
    parameter int unsigned NUM_FLOORS = 7,
    parameter int unsigned FLOOR_W    = $clog2(NUM_FLOORS)
);
    logic                  req_valid;
    logic [FLOOR_W-1:0]    req_floor;
    logic [FLOOR_W-1:0]    current_floor;
    logic                  arrived;
    logic                  dest_ready;
    logic                  dest_valid;
    logic [FLOOR_W-1:0]    dest_floor;
    logic                  next_up_ndown;
    logic [NUM_FLOORS-1:0] queue_status;
    logic                  queue_empty;
`ifdef ELEVATOR_DEST_CANCEL_EN
    logic                  req_cancel;
    logic [FLOOR_W-1:0]    cancel_floor;
`endif

    // Car/request side: drives requests and position, observes the scheduler
    modport master (
`ifdef ELEVATOR_DEST_CANCEL_EN
        output req_cancel,
        output cancel_floor,
`endif
        output req_valid,
        output req_floor,
        output current_floor,
        output arrived,
        output dest_ready,
        input  dest_valid,
        input  dest_floor,
        input  next_up_ndown,
        input  queue_status,
        input  queue_empty
    );

    // Scheduler side
    modport slave (
`ifdef ELEVATOR_DEST_CANCEL_EN
        input  req_cancel,
        input  cancel_floor,
`endif
        input  req_valid,
        input  req_floor,
        input  current_floor,
        input  arrived,
        input  dest_ready,
        output dest_valid,
        output dest_floor,
        output next_up_ndown,
        output queue_status,
        output queue_empty
    );
endinterface

// File: rtl/elevator_dest_sched.sv
// Elevator destination scheduler: collects floor requests into a bitmap,
// picks the next stop (same floor, then continue in direction, then reverse),
// offers it with a valid/ready handshake and retires it on arrival.
// Optional request cancellation: define ELEVATOR_DEST_CANCEL_EN.
module elevator_dest_sched #(
    parameter int unsigned NUM_FLOORS = 7,
    parameter int unsigned FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    elevator_dest_sched_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RESOLVE, OFFER, TRAVEL} state_t;

    state_t                state, state_nxt;
    logic [NUM_FLOORS-1:0] queue_q, queue_nxt;
    logic                  queue_empty_q;
    logic                  dest_valid_q, dest_valid_nxt;
    logic [FLOOR_W-1:0]    dest_q, dest_nxt;
    logic                  dir_q, dir_nxt;

    logic [NUM_FLOORS-1:0] req_mask, cancel_mask, dest_mask, arrive_mask;
    logic                  here_hit, above_found, below_found;
    logic [FLOOR_W-1:0]    above_floor, below_floor;
    logic                  abort;

    // Decode request, cancel and current destination into floor masks;
    // a request to the same floor overrides a cancel on the same edge
    always_comb begin
        req_mask    = '0;
        cancel_mask = '0;
        dest_mask   = '0;
        for (int unsigned f = 0; f < NUM_FLOORS; f++) begin
            req_mask[f]  = bus.req_valid && (bus.req_floor == FLOOR_W'(f));
            dest_mask[f] = (dest_q == FLOOR_W'(f));
`ifdef ELEVATOR_DEST_CANCEL_EN
            cancel_mask[f] = bus.req_cancel && (bus.cancel_floor == FLOOR_W'(f)) && !req_mask[f];
`endif
        end
    end

    // A cancel that takes effect on the floor being offered/travelled to aborts it
    always_comb begin
        abort = 1'b0;
`ifdef ELEVATOR_DEST_CANCEL_EN
        abort = bus.req_cancel && (bus.cancel_floor == dest_q) &&
                !(bus.req_valid && (bus.req_floor == bus.cancel_floor));
`endif
    end

    // Scan pending floors: hit at car, nearest above, nearest below
    always_comb begin
        here_hit    = 1'b0;
        above_found = 1'b0;
        below_found = 1'b0;
        above_floor = '0;
        below_floor = '0;
        for (int unsigned f = 0; f < NUM_FLOORS; f++) begin
            if (queue_q[f]) begin
                if (FLOOR_W'(f) == bus.current_floor) begin
                    here_hit = 1'b1;
                end
                if (FLOOR_W'(f) > bus.current_floor && !above_found) begin
                    above_found = 1'b1;
                    above_floor = FLOOR_W'(f);
                end
                if (FLOOR_W'(f) < bus.current_floor) begin
                    below_found = 1'b1;
                    below_floor = FLOOR_W'(f);
                end
            end
        end
    end

    // Next-state, next-output and queue update
    always_comb begin
        state_nxt      = state;
        dest_valid_nxt = dest_valid_q;
        dest_nxt       = dest_q;
        dir_nxt        = dir_q;
        arrive_mask    = '0;
        case (state)
            IDLE: begin
                dest_valid_nxt = 1'b0;
                if (!queue_empty_q) begin
                    state_nxt = RESOLVE;
                end
            end
            RESOLVE: begin
                state_nxt      = OFFER;
                dest_valid_nxt = 1'b1;
                if (here_hit) begin
                    dest_nxt = bus.current_floor;
                end else if (dir_q && above_found) begin
                    dest_nxt = above_floor;
                    dir_nxt  = 1'b1;
                end else if (below_found) begin
                    dest_nxt = below_floor;
                    dir_nxt  = 1'b0;
                end else if (above_found) begin
                    dest_nxt = above_floor;
                    dir_nxt  = 1'b1;
                end else begin
                    // Queue emptied by a cancel before resolution
                    state_nxt      = IDLE;
                    dest_valid_nxt = 1'b0;
                end
            end
            OFFER: begin
                if (abort) begin
                    state_nxt      = IDLE;
                    dest_valid_nxt = 1'b0;
                end else if (bus.dest_ready) begin
                    state_nxt      = TRAVEL;
                    dest_valid_nxt = 1'b0;
                end
            end
            TRAVEL: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (bus.arrived && (bus.current_floor == dest_q)) begin
                    arrive_mask = dest_mask;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                state_nxt      = IDLE;
                dest_valid_nxt = 1'b0;
            end
        endcase
        // Arrival clear beats a same-floor request; request beats cancel
        queue_nxt = ((queue_q & ~cancel_mask) | req_mask) & ~arrive_mask;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            queue_q       <= '0;
            queue_empty_q <= 1'b1;
            dest_valid_q  <= 1'b0;
            dest_q        <= '0;
            dir_q         <= 1'b1;
        end else begin
            state         <= state_nxt;
            queue_q       <= queue_nxt;
            queue_empty_q <= (queue_nxt == '0);
            dest_valid_q  <= dest_valid_nxt;
            dest_q        <= dest_nxt;
            dir_q         <= dir_nxt;
        end
    end

    assign bus.queue_status  = queue_q;
    assign bus.queue_empty   = queue_empty_q;
    assign bus.dest_valid    = dest_valid_q;
    assign bus.dest_floor    = dest_q;
    assign bus.next_up_ndown = dir_q;

endmodule

// File: tb/tb_elevator_dest_sched.sv
// Bench for elevator_dest_sched: directed scenarios followed by randomized
// traffic compared against a transaction-level scheduling model.
module tb_elevator_dest_sched;

    localparam int unsigned NF = 7;
    localparam int unsigned FW = 3;
    localparam int P_IDLE = 0, P_RESOLVE = 1, P_OFFER = 2, P_TRAVEL = 3;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    elevator_dest_sched_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus();

    elevator_dest_sched #(.NUM_FLOORS(NF), .FLOOR_W(FW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [NF-1:0] m_q;
    int            m_phase;
    int            m_dest;
    logic          m_dir;
    logic          m_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic quiet_inputs();
        bus.req_valid  = 1'b0;
        bus.arrived    = 1'b0;
        bus.dest_ready = 1'b0;
`ifdef ELEVATOR_DEST_CANCEL_EN
        bus.req_cancel   = 1'b0;
        bus.cancel_floor = '0;
`endif
    endtask

    task automatic pulse_req(input int f);
        bus.req_valid = 1'b1;
        bus.req_floor = FW'(f);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.dest_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus.dest_valid), 32'd1);
    endtask

    // Nearest pending floor walking away from c in the given direction, -1 if none
    function automatic int nearest(input logic [NF-1:0] q, input int c, input int step);
        for (int k = 1; k < int'(NF); k++) begin
            int f = c + step * k;
            if (f >= 0 && f < int'(NF) && q[f]) return f;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_q = '0; m_phase = P_IDLE; m_dest = 0; m_dir = 1'b1; m_valid = 1'b0;
    endtask

    // Advance the model across one rising edge given this cycle's inputs
    task automatic model_step(input bit rv, input int rf, input int cf, input bit arr,
                              input bit rdy, input bit cv, input int cfl);
        logic [NF-1:0] q = m_q;
        bit cancel_eff = cv && cfl < int'(NF) && !(rv && rf == cfl);
        bit abort = cancel_eff && cfl == m_dest;
        int up, dn;
        if (cancel_eff) q[cfl] = 1'b0;
        if (rv && rf < int'(NF)) q[rf] = 1'b1;
        case (m_phase)
            P_IDLE: if (m_q != '0) m_phase = P_RESOLVE;
            P_RESOLVE: begin
                up = nearest(m_q, cf, 1);
                dn = nearest(m_q, cf, -1);
                m_phase = P_OFFER; m_valid = 1'b1;
                if (m_q[cf]) m_dest = cf;
                else if (m_dir && up >= 0) begin m_dest = up; m_dir = 1'b1; end
                else if (dn >= 0) begin m_dest = dn; m_dir = 1'b0; end
                else if (up >= 0) begin m_dest = up; m_dir = 1'b1; end
                else begin m_phase = P_IDLE; m_valid = 1'b0; end
            end
            P_OFFER: begin
                if (abort) begin m_phase = P_IDLE; m_valid = 1'b0; end
                else if (rdy) begin m_phase = P_TRAVEL; m_valid = 1'b0; end
            end
            default: begin
                if (abort) m_phase = P_IDLE;
                else if (arr && cf == m_dest) begin q[m_dest] = 1'b0; m_phase = P_IDLE; end
            end
        endcase
        m_q = q;
    endtask

    initial begin
        rst_n = 1'b0;
        quiet_inputs();
        bus.req_floor     = '0;
        bus.current_floor = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(bus.dest_valid), 32'd0);
        check("rst_queue", 32'(bus.queue_status), 32'd0);
        check("rst_empty", 32'(bus.queue_empty), 32'd1);
        check("rst_dir",   32'(bus.next_up_ndown), 32'd1);
        check("rst_dest",  32'(bus.dest_floor), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Out-of-range floor is ignored
        pulse_req(7);
        check("oob_queue", 32'(bus.queue_status), 32'd0);
        check("oob_empty", 32'(bus.queue_empty), 32'd1);
        repeat (3) @(negedge clk);
        check("oob_no_offer", 32'(bus.dest_valid), 32'd0);

        // Single request: three-cycle latency, held while not ready
        pulse_req(3);
        check("lat_n1_valid", 32'(bus.dest_valid), 32'd0);
        check("lat_n1_queue", 32'(bus.queue_status), 32'h08);
        check("lat_n1_empty", 32'(bus.queue_empty), 32'd0);
        @(negedge clk);
        check("lat_n2_valid", 32'(bus.dest_valid), 32'd0);
        @(negedge clk);
        check("lat_n3_valid", 32'(bus.dest_valid), 32'd1);
        check("lat_n3_dest",  32'(bus.dest_floor), 32'd3);
        check("lat_n3_dir",   32'(bus.next_up_ndown), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_dest",  32'(bus.dest_floor), 32'd3);
            check("hold_valid", 32'(bus.dest_valid), 32'd1);
        end
        bus.dest_ready = 1'b1;
        @(negedge clk);
        bus.dest_ready = 1'b0;
        check("hs_drop", 32'(bus.dest_valid), 32'd0);

        // While travelling to 3: add 1 and 6, plus a stray arrival at 4
        bus.current_floor = 3'd4;
        pulse_req(1);
        bus.arrived = 1'b1;
        pulse_req(6);
        bus.arrived = 1'b0;
        check("stray_queue", 32'(bus.queue_status), 32'h4a);
        check("stray_valid", 32'(bus.dest_valid), 32'd0);
        bus.current_floor = 3'd3;
        bus.arrived = 1'b1;
        @(negedge clk);
        bus.arrived = 1'b0;
        bus.current_floor = 3'd4;
        check("arrive3_queue", 32'(bus.queue_status), 32'h42);

        // From floor 4 going up with 1 and 6 pending: continue up to 6
        wait_valid("up_offer");
        check("up_dest",  32'(bus.dest_floor), 32'd6);
        check("up_dir",   32'(bus.next_up_ndown), 32'd1);
        check("up_queue", 32'(bus.queue_status), 32'h42);
        bus.dest_ready = 1'b1;
        @(negedge clk);
        bus.dest_ready = 1'b0;
        bus.current_floor = 3'd2;
        bus.arrived = 1'b1;
        @(negedge clk);
        bus.arrived = 1'b0;
        check("wrong_floor_queue", 32'(bus.queue_status), 32'h42);
        repeat (2) @(negedge clk);
        check("wrong_floor_still_travel", 32'(bus.dest_valid), 32'd0);

        // Arrival at 6 on the same edge as a new request for 6: clear wins
        bus.current_floor = 3'd6;
        bus.arrived = 1'b1;
        pulse_req(6);
        bus.arrived = 1'b0;
        check("clear_wins_queue", 32'(bus.queue_status), 32'h02);
        wait_valid("down_offer");
        check("down_dest", 32'(bus.dest_floor), 32'd1);
        check("down_dir",  32'(bus.next_up_ndown), 32'd0);

        // Asynchronous reset in the middle of an offer
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", 32'(bus.dest_valid), 32'd0);
        check("async_queue", 32'(bus.queue_status), 32'd0);
        check("async_empty", 32'(bus.queue_empty), 32'd1);
        check("async_dir",   32'(bus.next_up_ndown), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", 32'(bus.dest_valid), 32'd0);

`ifdef ELEVATOR_DEST_CANCEL_EN
        // Cancel the floor currently offered
        bus.current_floor = 3'd0;
        pulse_req(6);
        wait_valid("cancel_offer");
        check("cancel_dest", 32'(bus.dest_floor), 32'd6);
        bus.req_cancel   = 1'b1;
        bus.cancel_floor = 3'd6;
        @(negedge clk);
        bus.req_cancel = 1'b0;
        check("cancel_valid", 32'(bus.dest_valid), 32'd0);
        check("cancel_queue", 32'(bus.queue_status), 32'd0);
`endif

        // Randomized traffic against the model
        rst_n = 1'b0;
        quiet_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit rv, arr, rdy, cv;
            int rf, cf, cfl;
            check("rnd_valid", 32'(bus.dest_valid), 32'(m_valid));
            check("rnd_queue", 32'(bus.queue_status), 32'(m_q));
            check("rnd_empty", 32'(bus.queue_empty), 32'(m_q == '0));
            check("rnd_dest",  32'(bus.dest_floor), 32'(m_dest));
            check("rnd_dir",   32'(bus.next_up_ndown), 32'(m_dir));
            rv  = ($urandom_range(0, 2) == 0);
            rf  = int'($urandom_range(0, 7));
            cf  = (m_phase == P_TRAVEL && $urandom_range(0, 1) == 1) ? m_dest
                                                                    : int'($urandom_range(0, 6));
            arr = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 2) == 0);
            cv  = 1'b0;
            cfl = 0;
`ifdef ELEVATOR_DEST_CANCEL_EN
            cv  = ($urandom_range(0, 7) == 0);
            cfl = int'($urandom_range(0, 7));
            bus.req_cancel   = cv;
            bus.cancel_floor = FW'(cfl);
`endif
            bus.req_valid     = rv;
            bus.req_floor     = FW'(rf);
            bus.current_floor = FW'(cf);
            bus.arrived       = arr;
            bus.dest_ready    = rdy;
            model_step(rv, rf, cf, arr, rdy, cv, cfl);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/elevator_dest_sched.md
ELEVATOR_DEST_SCHED -- requirements
Module: elevator_dest_sched

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 7, number of served floors (2..32).
REQ-002 SHALL have parameter FLOOR_W, default $clog2(NUM_FLOORS), floor index width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  one-cycle floor request strobe.
REQ-006 SHALL have port req_floor  input  FLOOR_W  requested floor, sampled when req_valid=1.
REQ-007 SHALL have port current_floor  input  FLOOR_W  car position.
REQ-008 SHALL have port arrived  input  1  one-cycle pulse: car stopped at current_floor.
REQ-009 SHALL have port dest_ready  input  1  motion controller accepts dest_floor.
REQ-010 SHALL have port dest_valid  output  1  dest_floor offered.
REQ-011 SHALL have port dest_floor  output  FLOOR_W  resolved destination.
REQ-012 SHALL have port next_up_ndown  output  1  travel direction, 1=up, 0=down.
REQ-013 SHALL have port queue_status  output  NUM_FLOORS  pending-request bitmap, bit f = floor f.
REQ-014 SHALL have port queue_empty  output  1  high when queue_status==0.

Function
REQ-015 SHALL set queue_status[req_floor] on the edge ending a req_valid cycle; req_floor>=NUM_FLOORS ignored; duplicate requests idempotent.
REQ-016 SHALL implement FSM IDLE, RESOLVE, OFFER, TRAVEL; all outputs registered.
REQ-017 IDLE: dest_valid=0; next state RESOLVE when queue_empty=0, else stay.
REQ-018 RESOLVE (one cycle): with c=current_floor, q=queue_status, d=next_up_ndown: if q[c] -> dest=c, d unchanged; else if d=1 and any q above c -> nearest above, d=1; else if any q below c -> nearest below, d=0; else nearest above, d=1 (mirror for d=0: prefer below, then above, d=1). Next state OFFER.
REQ-019 OFFER: dest_valid=1, dest_floor and next_up_ndown held stable until dest_ready=1; handshake completes on cycle with dest_valid=1 and dest_ready=1, next state TRAVEL, dest_valid=0 next cycle.
REQ-020 TRAVEL: on arrived=1 with current_floor==dest_floor, clear queue_status[dest_floor], next state IDLE; arrived at any other floor ignored.
REQ-021 Same-edge request and clear of the same floor: clear wins (car is serving it); different floors: both apply.
REQ-022 New requests during RESOLVE/OFFER/TRAVEL SHALL set bits but not retarget the current dest_floor.
REQ-023 Latency: request into empty queue in IDLE at cycle N -> dest_valid=1 at cycle N+3.
REQ-024 queue_empty SHALL equal NOR of registered queue_status in the same cycle.

Reset
REQ-025 While rst_n=0, asynchronously: state=IDLE, queue_status=0, queue_empty=1, next_up_ndown=1, dest_floor=0, dest_valid=0.
REQ-026 Reset mid-OFFER or mid-TRAVEL SHALL drop the in-flight destination and all pending requests; operation resumes from IDLE on first edge after release.

Configuration
REQ-027 With macro ELEVATOR_DEST_CANCEL_EN defined, ports req_cancel (input 1) and cancel_floor (input FLOOR_W) SHALL exist; req_cancel=1 clears queue_status[cancel_floor]; if that floor equals dest_floor in OFFER or TRAVEL, dest_valid drops and FSM returns to IDLE next edge; cancel and request of same floor on same edge: request wins.
REQ-028 Without ELEVATOR_DEST_CANCEL_EN, those ports SHALL be absent and requests clear only by arrival.

Verification (NUM_FLOORS=7)
REQ-029 Reset: assert rst_n=0 mid-OFFER -> dest_valid=0, queue_status=0, queue_empty=1, next_up_ndown=1 immediately, no clock needed.
REQ-030 current_floor=4, d=1, requests floors 1 and 6 (queue_status=7'b1000010) -> dest_floor=6, next_up_ndown=1; after arrived at 6 -> queue_status=7'b0000010, then dest_floor=1, next_up_ndown=0.
REQ-031 Single request floor 3 from empty IDLE at cycle N -> dest_valid=1 at N+3; dest_ready held 0 for 5 cycles -> dest_floor stays 3.
REQ-032 TRAVEL to 5, arrived at 2 -> no change; arrived at 5 same edge as req_floor=5 -> bit 5 clear, FSM IDLE.
REQ-033 req_floor=7 -> queue_status unchanged, queue_empty stays 1.
REQ-034 With ELEVATOR_DEST_CANCEL_EN: dest_floor=6 in OFFER, cancel floor 6 -> dest_valid=0 next cycle, bit 6 cleared.
